// File: rtl/mem_bank_array.sv
// Multi-bank scratchpad: shared address/write bus, one-hot bank requests, registered reads.
// Optional MEM_BANK_SKIP_INIT_EN removes the post-reset zeroing sweep.
module mem_bank_array #(
  parameter int NUM_BANKS = 5,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 17,
  parameter int DEPTH     = 1280
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          read_rq,
  input  logic [NUM_BANKS-1:0]          write_rq,
  input  logic [ADDR_W-1:0]             rw_address,
  input  logic [DATA_W-1:0]             write_data,
  output logic [NUM_BANKS*DATA_W-1:0]   read_data,
  output logic [NUM_BANKS-1:0]          rd_valid,
  output logic                          ready,
  output logic                          err,
  output logic [7:0]                    err_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic          addr_ok;
  logic          one_hot;
  logic          any_rq;
  logic          legal;
  logic          illegal;
  logic          init_we;

  assign idx     = rw_address[IW-1:0];
  assign addr_ok = 32'(rw_address) < 32'(DEPTH);
  assign one_hot = $onehot({read_rq, write_rq});
  assign any_rq  = |{read_rq, write_rq};
  assign ready   = (state == S_RUN);
  assign legal   = ready && one_hot && addr_ok;
  assign illegal = ready && any_rq && !legal;

`ifdef MEM_BANK_SKIP_INIT_EN
  assign init_we = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= S_RUN;
  end
`else
  logic [IW-1:0] init_addr;

  // Held in S_INIT during reset too, so addr 0 may be rewritten with 0 then.
  assign init_we = (state == S_INIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      init_addr <= '0;
    end else if (state == S_INIT) begin
      if (init_addr == IW'(DEPTH - 1)) state <= S_RUN;
      else init_addr <= init_addr + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= illegal;
      if (illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
`ifdef MEM_BANK_SKIP_INIT_EN
      if (legal && write_rq[b]) mem[idx] <= write_data;
`else
      if (init_we) mem[init_addr] <= '0;
      else if (legal && write_rq[b]) mem[idx] <= write_data;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata       <= '0;
        rd_valid[b] <= 1'b0;
      end else begin
        rd_valid[b] <= legal && read_rq[b];
        if (legal && read_rq[b]) rdata <= mem[idx];
      end
    end

    assign read_data[b*DATA_W +: DATA_W] = rdata;
  end

endmodule

// File: tb/tb_mem_bank_array.sv
// Directed bench for mem_bank_array with a read scoreboard and reference memory.
// Build with MEM_BANK_SKIP_INIT_EN to exercise the no-sweep variant.
module tb_mem_bank_array;

  localparam int NB = 5;
  localparam int DW = 8;
  localparam int AW = 17;
  localparam int D  = 16;
`ifdef MEM_BANK_SKIP_INIT_EN
  localparam int SWEEP = 1;
`else
  localparam int SWEEP = D;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NB-1:0]    read_rq = '0;
  logic [NB-1:0]    write_rq = '0;
  logic [AW-1:0]    rw_address = '0;
  logic [DW-1:0]    write_data = '0;
  logic [NB*DW-1:0] read_data;
  logic [NB-1:0]    rd_valid;
  logic             ready;
  logic             err;
  logic [7:0]       err_cnt;

  mem_bank_array #(
    .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .read_rq(read_rq), .write_rq(write_rq),
    .rw_address(rw_address), .write_data(write_data),
    .read_data(read_data), .rd_valid(rd_valid),
    .ready(ready), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         b;
    logic [7:0] d;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [NB][D];
  logic [7:0] rdm [NB];
  int         exp_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB*DW-1:0] pk();
    logic [NB*DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = rdm[b];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_model();
    for (int b = 0; b < NB; b++) begin
      rdm[b] = '0;
      for (int a = 0; a < D; a++) mdl[b][a] = '0;
    end
    exp_cnt = 0;
  endtask

  task automatic do_write(int b, int a, logic [7:0] d);
    write_rq   = NB'(1 << b);
    rw_address = AW'(a);
    write_data = d;
    step();
    write_rq = '0;
    mdl[b][a] = d;
    chk("wr_err", 64'(err), 64'(0));
    chk("wr_rdv", 64'(rd_valid), 64'(0));
  endtask

  task automatic do_read(int b, int a);
    exp_t e;
    read_rq    = NB'(1 << b);
    rw_address = AW'(a);
    sbq.push_back('{b: b, d: mdl[b][a]});
    step();
    read_rq = '0;
    chk("rd_valid", 64'(rd_valid), 64'(1 << b));
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      rdm[e.b] = e.d;
    end
    chk("rd_data", 64'(read_data), 64'(pk()));
    chk("rd_err", 64'(err), 64'(0));
  endtask

  task automatic do_bad(logic [NB-1:0] r, logic [NB-1:0] w, int a);
    read_rq    = r;
    write_rq   = w;
    rw_address = AW'(a);
    write_data = 8'hFF;
    step();
    read_rq  = '0;
    write_rq = '0;
    if (exp_cnt < 255) exp_cnt++;
    chk("bad_err", 64'(err), 64'(1));
    chk("bad_cnt", 64'(err_cnt), 64'(exp_cnt));
    chk("bad_rdv", 64'(rd_valid), 64'(0));
    chk("bad_rdata", 64'(read_data), 64'(pk()));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_rdata"}, 64'(read_data), 64'(0));
    chk({tag, "_rdv"}, 64'(rd_valid), 64'(0));
    chk({tag, "_ready"}, 64'(ready), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_cnt"}, 64'(err_cnt), 64'(0));
  endtask

  task automatic wait_ready(string tag, int exp_n, logic busy);
    int n = 0;
    while (n < 100) begin
      step();
      n++;
      if (ready) break;
      if (busy) begin
        chk({tag, "_busy_err"}, 64'(err), 64'(0));
        chk({tag, "_busy_rdv"}, 64'(rd_valid), 64'(0));
      end
    end
    read_rq  = '0;
    write_rq = '0;
    chk({tag, "_len"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    clr_model();
    #1 rst = 1'b0;
    #1 chk_reset("rst0");
    step();
    step();
    chk_reset("rst1");
    rst = 1'b1;
    wait_ready("sweep", SWEEP, 1'b0);

`ifdef MEM_BANK_SKIP_INIT_EN
    do_write(2, 0, 8'h3C);
    do_read(2, 0);
    do_write(0, 7, 8'hA5);
    do_read(0, 7);
    do_bad(5'b00010, 5'b00010, 2);
    do_write(4, 3, 8'h5A);
    do_read(4, 3);
    do_bad(5'b10000, 5'b00000, 16);
    step();
    chk("err_drop", 64'(err), 64'(0));
    do_read(2, 0);
`else
    do_read(3, 15);
    do_write(0, 7, 8'hA5);
    do_read(0, 7);
    do_read(1, 7);
    do_write(4, 15, 8'hC3);
    do_read(4, 15);
    step();
    chk("idle_rdv", 64'(rd_valid), 64'(0));
    chk("idle_err", 64'(err), 64'(0));
    chk("idle_rdata", 64'(read_data), 64'(pk()));

    do_write(1, 2, 8'h11);
    do_bad(5'b00010, 5'b00010, 2);
    step();
    chk("err_drop", 64'(err), 64'(0));
    do_read(1, 2);
    for (int i = 0; i < 300; i++) do_bad(5'b00010, 5'b00010, 2);
    chk("cnt_sat", 64'(err_cnt), 64'(255));
    do_read(1, 2);

    do_write(4, 3, 8'h5A);
    do_read(4, 3);
    do_bad(5'b10000, 5'b00000, 16);
    do_bad(5'b00000, 5'b10000, 16);
    do_read(4, 0);
    do_bad(5'b00101, 5'b00000, 1);

    rst = 1'b0;
    #1 chk_reset("mid_run");
    step();
    rst = 1'b1;
    clr_model();
    for (int i = 0; i < 8; i++) step();
    rst = 1'b0;
    #1 chk_reset("mid_sweep");
    step();
    rst = 1'b1;
    write_rq   = 5'b00001;
    rw_address = AW'(7);
    write_data = 8'hFF;
    wait_ready("resweep", D, 1'b1);
    chk("resweep_cnt", 64'(err_cnt), 64'(0));
    do_read(0, 7);
    do_read(3, 15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
